// File: rtl/rv_mem_arbiter_if.sv
// Shared single-ported memory bus between the arbiter and external memory.
// Signal names match the arbiter's bus pins.
interface rv_mem_arbiter_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_data_o,
        output mem_sel_o,
        input  mem_data_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_data_o,
        input  mem_sel_o,
        output mem_data_i,
        output mem_ack_i
    );
endinterface

// File: rtl/rv_mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between fetch and load/store.
// Includes a bus timeout and kill of fetch results after taken branches.
module rv_mem_arbiter #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        im_req_i,
    input  logic [31:0] im_addr_i,
    input  logic        im_kill_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    output logic        im_done_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_i,
    input  logic [3:0]  dm_sel_i,
    output logic [31:0] dm_data_o,
    output logic        dm_done_o,
    output logic        err_o,
    rv_mem_arbiter_if.master mem
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam bit          TMO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic        last_dm_q;
    logic        gnt_dm_q;
    logic        kill_q;
    logic [15:0] cnt_q;

    logic pick_dm;
    logic any_req;
    logic tmo;

    // Ties go to whichever port did not win last time.
    assign pick_dm = dm_req_i & (~im_req_i | ~last_dm_q);
    assign any_req = im_req_i | dm_req_i;
    assign tmo     = TMO_EN && (cnt_q == TMO_LAST);

    // A kill in the response cycle itself still suppresses the result.
    assign im_valid_o = im_done_o & ~kill_q & ~im_kill_i & ~err_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            last_dm_q      <= 1'b0;
            gnt_dm_q       <= 1'b0;
            kill_q         <= 1'b0;
            cnt_q          <= '0;
            im_data_o      <= '0;
            im_done_o      <= 1'b0;
            dm_data_o      <= '0;
            dm_done_o      <= 1'b0;
            err_o          <= 1'b0;
            mem.mem_req_o  <= 1'b0;
            mem.mem_we_o   <= 1'b0;
            mem.mem_addr_o <= '0;
            mem.mem_data_o <= '0;
            mem.mem_sel_o  <= '0;
        end else begin
            im_done_o <= 1'b0;
            dm_done_o <= 1'b0;
            err_o     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q       <= BUSY;
                        gnt_dm_q      <= pick_dm;
                        last_dm_q     <= pick_dm;
                        cnt_q         <= '0;
                        kill_q        <= ~pick_dm & im_kill_i;
                        mem.mem_req_o <= 1'b1;
                        if (pick_dm) begin
                            mem.mem_we_o   <= dm_we_i;
                            mem.mem_addr_o <= dm_addr_i;
                            mem.mem_data_o <= dm_data_i;
                            mem.mem_sel_o  <= dm_sel_i;
                        end else begin
                            mem.mem_we_o   <= 1'b0;
                            mem.mem_addr_o <= im_addr_i;
                            mem.mem_data_o <= '0;
                            mem.mem_sel_o  <= 4'hF;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (!gnt_dm_q && im_kill_i) kill_q <= 1'b1;
                    if (mem.mem_ack_i || tmo) begin
                        state_q       <= RESP;
                        mem.mem_req_o <= 1'b0;
                        err_o         <= ~mem.mem_ack_i;
                        if (gnt_dm_q) begin
                            dm_done_o <= 1'b1;
                            dm_data_o <= mem.mem_ack_i ? mem.mem_data_i : '0;
                        end else begin
                            im_done_o <= 1'b1;
                            im_data_o <= mem.mem_ack_i ? mem.mem_data_i : '0;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    kill_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Shares one single-ported memory bus between the instruction-fetch port and the load/store (data) port of the core.
- Each transaction is latched and driven onto the bus with a req/ack handshake.
- The response is routed back to the winning requester.
- Includes round-robin fairness, a bus timeout, and suppression of fetch responses killed by a taken branch.
- Sits between the fetch/execute stages and the external memory.

Parameters:
TIMEOUT, 256, cycles to wait for mem_ack_i before aborting; 0 disables the timeout; max 65535.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
im_req_i  in  1  fetch request; held until im_done_o
im_addr_i  in  32  fetch address
im_kill_i  in  1  branch taken: discard in-flight fetch result
im_data_o  out  32  fetched word
im_valid_o  out  1  fetch data valid (1-cycle pulse)
im_done_o  out  1  fetch transaction finished, valid or not (1-cycle pulse)
dm_req_i  in  1  data request; held until dm_done_o
dm_we_i  in  1  1 = write
dm_addr_i  in  32  data address
dm_data_i  in  32  write data
dm_sel_i  in  4  byte enables
dm_data_o  out  32  read data
dm_done_o  out  1  data transaction finished (1-cycle pulse)
mem_req_o  out  1  bus request; held until ack or timeout
mem_we_o  out  1  bus write enable
mem_addr_o  out  32  bus address
mem_data_o  out  32  bus write data
mem_sel_o  out  4  bus byte enables
mem_data_i  in  32  bus read data, valid with mem_ack_i
mem_ack_i  in  1  bus completion
err_o  out  1  timeout pulse (1 cycle, coincident with done)

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant=IM, kill flag 0, timeout counter 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both req: grant the port not granted last. First tie after reset goes to DM.
  - On grant: latch addr/we/data/sel into mem_* (IM grant forces we=0, sel=4'hF, data=0). Next cycle mem_req_o=1, state BUSY, last_grant updated, counter cleared.
- BUSY:
  - mem_* held stable; counter increments each cycle.
  - On mem_ack_i: capture mem_data_i into a response register, drop mem_req_o next cycle, go to RESP.
  - If TIMEOUT!=0 and counter reaches TIMEOUT-1 without ack: drop mem_req_o, response data forced to 0, set error flag, go to RESP.
  - Ack in the same cycle as timeout expiry counts as ack (no error).
- RESP (exactly 1 cycle):
  - Winner's done pulses; err_o pulses if the error flag is set; requests are ignored.
  - Next state is IDLE; error flag cleared.
  - Requesters must drop or update req in the cycle after done.
- Data outputs: im_data_o and dm_data_o hold the last captured value between transactions.
- Latency: req seen in IDLE at cycle N → mem_req_o at N+1 → ack at cycle M≥N+1 → done at M+1 → next arbitration at M+2. Minimum 3 cycles per transaction.
- Fetch response:
  - im_valid_o = done & !kill & !err.
  - Kill flag is set by im_kill_i in any cycle from grant through the RESP cycle inclusive, and cleared on entering IDLE.
  - im_kill_i while IM is not granted has no effect.
- Data transactions are never killed. dm_data_o is meaningful only for reads.
- mem_ack_i outside BUSY is ignored.
- rst_i mid-transaction: immediate return to IDLE with mem_req_o=0 next cycle. A pending bus cycle is abandoned; the memory side must tolerate this.
- Requesters may assert req in any cycle; input changes while granted are ignored because the outputs are latched.

Test Plan:
- IM only, im_addr_i=0x100, memory acks 2 cycles after mem_req_o with 0x00000013 → mem_addr_o=0x100, mem_we_o=0; im_data_o=0x13 with im_valid_o=im_done_o=1 one cycle after ack; dm_done_o=0.
- DM write addr=0x2000, data=0xDEADBEEF, sel=0x3 → mem_we_o=1, mem_sel_o=0x3, mem_data_o=0xDEADBEEF held until ack; dm_done_o pulses once.
- im_req_i and dm_req_i both high continuously after reset, ack every cycle → grants DM, IM, DM, IM…; mem_req_o never high in a RESP cycle.
- IM granted, im_kill_i pulsed while BUSY, ack data 0x55 → im_done_o=1, im_valid_o=0; next fetch with a new address completes with im_valid_o=1.
- TIMEOUT=4, no ack → mem_req_o high exactly 4 cycles; then err_o=1, dm_done_o=1, dm_data_o=0; the following ack is ignored.
- rst_i asserted in BUSY → next cycle mem_req_o=0 and all outputs 0; the first tie after reset goes to DM again.
